impulse_count_receiver: RTL and testbench

Receive-side counterpart of the multi-channel impulse counter's serial readout port. Deserialises the count stream carried on serial/SL/address lines back into a per-channel count register bank, together with the global and RTC overflow flags. Sits in the host-side logic (FPGA/MCU bridge or loopback test harness). Exposes the bank to a simple registered read port.

---
 rtl/impulse_pkg.sv | 14 +
 rtl/impulse_rx_deser.sv | 70 +++++++
 rtl/impulse_count_receiver.sv | 107 ++++++++++
 tb/tb_impulse_count_receiver.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/impulse_pkg.sv
// Shared types and default sizing for the impulse-count readout receiver.
package impulse_pkg;
  localparam int N_CH_DEF    = 8;
  localparam int COUNT_W_DEF = 16;
  localparam int ADDR_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } rx_state_t;

  typedef logic [COUNT_W_DEF-1:0] count_t;
endpackage

// File: rtl/impulse_rx_deser.sv
// Word deserialiser: load strobe latches the address, then COUNT_W bits MSB-first,
// then a one-cycle COMMIT during which word/addr are presented with strobe high.
module impulse_rx_deser
  import impulse_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_in,
  input  logic              sl_in,
  input  logic [ADDR_W-1:0] addr_in,
  output logic [COUNT_W-1:0] word,
  output logic [ADDR_W-1:0] addr,
  output logic              strobe,
  output logic              abort
);
  localparam int CNT_W = $clog2(COUNT_W + 1);

  rx_state_t          state;
  logic [CNT_W-1:0]   cnt;
  logic [COUNT_W-1:0] sr;
  logic [ADDR_W-1:0]  addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      sr     <= '0;
      addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sl_in) begin
            addr_q <= addr_in;
            cnt    <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          // An early load abandons the partial word and starts over
          if (sl_in) begin
            addr_q <= addr_in;
            cnt    <= '0;
          end else begin
            sr  <= {sr[COUNT_W-2:0], serial_in};
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(COUNT_W - 1)) state <= COMMIT;
          end
        end
        COMMIT: begin
          if (sl_in) begin
            addr_q <= addr_in;
            cnt    <= '0;
            state  <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign word   = sr;
  assign addr   = addr_q;
  assign strobe = (state == COMMIT);
  assign abort  = (state == SHIFT) && sl_in;
endmodule

// File: rtl/impulse_count_receiver.sv
// Receiver top: count bank, received-mask, sticky flags and registered read port.
// IMPULSE_RX_SNAPSHOT_EN: double-buffer the bank so reads see whole completed frames.
module impulse_count_receiver
  import impulse_pkg::*;
#(
  parameter int N_CH    = N_CH_DEF,
  parameter int COUNT_W = COUNT_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               serial_in,
  input  logic               sl_in,
  input  logic [ADDR_W-1:0]  addr_in,
  input  logic               ovf_global_in,
  input  logic               ovf_rtc_in,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [COUNT_W-1:0] rd_data,
  output logic               word_valid,
  output logic [ADDR_W-1:0]  word_addr,
  output logic               frame_done,
  output logic               ovf_global,
  output logic               ovf_rtc,
  output logic               err
);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [COUNT_W-1:0] word;
  logic [ADDR_W-1:0]  waddr;
  logic               strobe, abort;

  impulse_rx_deser #(.COUNT_W(COUNT_W), .ADDR_W(ADDR_W)) u_deser (
    .clk       (clk),
    .reset     (reset),
    .serial_in (serial_in),
    .sl_in     (sl_in),
    .addr_in   (addr_in),
    .word      (word),
    .addr      (waddr),
    .strobe    (strobe),
    .abort     (abort)
  );

  logic              addr_ok, rd_ok, commit_ok, rtc_q;
  logic [IDX_W-1:0]  widx, ridx;
  logic [ADDR_W-1:0] last_addr;
  logic [N_CH-1:0]   mask, mask_next;

  assign addr_ok   = {1'b0, waddr} < (ADDR_W+1)'(N_CH);
  assign rd_ok     = {1'b0, rd_addr} < (ADDR_W+1)'(N_CH);
  assign widx      = waddr[IDX_W-1:0];
  assign ridx      = rd_addr[IDX_W-1:0];
  assign commit_ok = strobe && addr_ok;

  // word_valid/word_addr come straight off the COMMIT state register
  assign word_valid = commit_ok;
  assign word_addr  = commit_ok ? waddr : last_addr;

  always_comb begin
    mask_next = mask;
    if (commit_ok) mask_next[widx] = 1'b1;
  end

`ifdef IMPULSE_RX_SNAPSHOT_EN
  logic [N_CH-1:0][COUNT_W-1:0] shadow;
`endif
  logic [N_CH-1:0][COUNT_W-1:0] rbank;

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef IMPULSE_RX_SNAPSHOT_EN
      shadow     <= '0;
`endif
      rbank      <= '0;
      mask       <= '0;
      frame_done <= 1'b0;
      last_addr  <= '0;
      ovf_global <= 1'b0;
      ovf_rtc    <= 1'b0;
      rtc_q      <= 1'b0;
      err        <= 1'b0;
      rd_data    <= '0;
    end else begin
      if (commit_ok) last_addr <= waddr;
`ifdef IMPULSE_RX_SNAPSHOT_EN
      if (commit_ok) shadow[widx] <= word;
      // shadow already holds the completing word by the time frame_done is high
      if (frame_done) rbank <= shadow;
`else
      if (commit_ok) rbank[widx] <= word;
`endif
      if (commit_ok && (&mask_next)) begin
        mask       <= '0;
        frame_done <= 1'b1;
      end else begin
        mask       <= mask_next;
        frame_done <= 1'b0;
      end
      if (abort || (strobe && !addr_ok)) err <= 1'b1;
      if (strobe && ovf_global_in) ovf_global <= 1'b1;
      rtc_q <= ovf_rtc_in;
      if (ovf_rtc_in && !rtc_q) ovf_rtc <= 1'b1;
      // Reads the pre-write bank, so a same-cycle commit returns the old value
      rd_data <= rd_ok ? rbank[ridx] : '0;
    end
  end
endmodule

// File: tb/tb_impulse_count_receiver.sv
// Directed bench for impulse_count_receiver: readback tables plus hand-built corner sequences.
module tb_impulse_count_receiver;
  logic        clk = 1'b0;
  logic        reset, serial_in, sl_in, ovf_global_in, ovf_rtc_in;
  logic [3:0]  addr_in, rd_addr, word_addr;
  logic [15:0] rd_data;
  logic        word_valid, frame_done, ovf_global, ovf_rtc, err;

  impulse_count_receiver dut (
    .clk           (clk),
    .reset         (reset),
    .serial_in     (serial_in),
    .sl_in         (sl_in),
    .addr_in       (addr_in),
    .ovf_global_in (ovf_global_in),
    .ovf_rtc_in    (ovf_rtc_in),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .word_valid    (word_valid),
    .word_addr     (word_addr),
    .frame_done    (frame_done),
    .ovf_global    (ovf_global),
    .ovf_rtc       (ovf_rtc),
    .err           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
  } rd_vec_t;

  int ncyc = 0, wv_cnt = 0, fd_cnt = 0, wv_cyc = 0, fd_cyc = 0, load_cyc = 0;
  int total = 0, bad = 0;
  logic [3:0] wv_addr = '0;

  always @(posedge clk) ncyc <= ncyc + 1;

  always @(negedge clk) begin
    if (word_valid) begin
      wv_cnt  = wv_cnt + 1;
      wv_cyc  = ncyc;
      wv_addr = word_addr;
    end
    if (frame_done) begin
      fd_cnt = fd_cnt + 1;
      fd_cyc = ncyc;
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask

  task automatic step(input logic sl, input logic ser, input logic [3:0] a);
    sl_in = sl; serial_in = ser; addr_in = a;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 4'd0);
  endtask

  task automatic send(input logic [3:0] a, input logic [15:0] d, input int nb);
    load_cyc = ncyc;
    step(1'b1, 1'b0, a);
    for (int i = 0; i < nb; i++) step(1'b0, d[15-i], 4'd0);
  endtask

  task automatic rdchk(input string n, input logic [3:0] a, input logic [15:0] exp);
    rd_addr = a;
    step(1'b0, 1'b0, 4'd0);
    chk(n, 32'(rd_data), 32'(exp));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  rd_vec_t vt[10];
  int w0, f0;
  logic [15:0] e;

  initial begin
    sl_in = 0; serial_in = 0; addr_in = 0; rd_addr = 0;
    ovf_global_in = 0; ovf_rtc_in = 0; reset = 1;
    @(negedge clk);
    do_reset();

    // reset state
    chk("rst_outs", {16'(rd_data), word_valid, 4'(word_addr), frame_done, ovf_global, ovf_rtc, err}, 0);

    // single word, latency and readback
    w0 = wv_cnt;
    send(4'd3, 16'hA5C3, 16);
    idle(3);
    chk("t1_wv_count", wv_cnt - w0, 1);
    chk("t1_latency", wv_cyc - load_cyc, 17);
    chk("t1_wv_addr", 32'(wv_addr), 3);
    chk("t1_word_addr_hold", 32'(word_addr), 3);
`ifdef IMPULSE_RX_SNAPSHOT_EN
    e = 16'h0000;
`else
    e = 16'hA5C3;
`endif
    rdchk("t1_rd3", 4'd3, e);

    // back-to-back full frame, loads land in COMMIT cycles
    do_reset();
    w0 = wv_cnt; f0 = fd_cnt;
    for (int c = 0; c < 8; c++) send(4'(c), 16'(c + 1), 16);
    idle(3);
    chk("t2_wv_count", wv_cnt - w0, 8);
    chk("t2_fd_count", fd_cnt - f0, 1);
    chk("t2_fd_after_ch7", fd_cyc - wv_cyc, 1);
    chk("t2_err", 32'(err), 0);
    for (int i = 0; i < 8; i++) begin
      vt[i].a = 4'(i);
      vt[i].d = 16'(i + 1);
    end
    vt[8].a = 4'd9;  vt[8].d = 16'h0000;
    vt[9].a = 4'd15; vt[9].d = 16'h0000;
    for (int i = 0; i < 10; i++) rdchk($sformatf("t2_rd%0d", vt[i].a), vt[i].a, vt[i].d);

    // abort after 5 bits, then a clean word for the same channel
    do_reset();
    w0 = wv_cnt;
    send(4'd2, 16'hFFFF, 5);
    send(4'd2, 16'h1234, 16);
    idle(3);
    chk("t3_err", 32'(err), 1);
    chk("t3_wv_count", wv_cnt - w0, 1);
    chk("t3_wv_addr", 32'(wv_addr), 2);
`ifdef IMPULSE_RX_SNAPSHOT_EN
    e = 16'h0000;
`else
    e = 16'h1234;
`endif
    rdchk("t3_rd2", 4'd2, e);

    // out-of-range channel address
    do_reset();
    send(4'd1, 16'h0BEE, 16);
    idle(2);
    chk("t4_err_pre", 32'(err), 0);
    w0 = wv_cnt;
    send(4'd9, 16'hFFFF, 16);
    idle(3);
    chk("t4_err", 32'(err), 1);
    chk("t4_no_wv", wv_cnt - w0, 0);
`ifdef IMPULSE_RX_SNAPSHOT_EN
    e = 16'h0000;
`else
    e = 16'h0BEE;
`endif
    rdchk("t4_rd1", 4'd1, e);
    rdchk("t4_rd9", 4'd9, 16'h0000);

    // overflow flags
    do_reset();
    ovf_global_in = 1'b1;
    idle(2);
    ovf_global_in = 1'b0;
    idle(1);
    chk("t5_ovfg_not_commit", 32'(ovf_global), 0);
    send(4'd0, 16'h0042, 16);
    ovf_global_in = 1'b1;
    step(1'b0, 1'b0, 4'd0);
    ovf_global_in = 1'b0;
    idle(1);
    chk("t5_ovfg_set", 32'(ovf_global), 1);
    chk("t5_ovfr_clear", 32'(ovf_rtc), 0);
    ovf_rtc_in = 1'b1;
    step(1'b0, 1'b0, 4'd0);
    ovf_rtc_in = 1'b0;
    idle(2);
    chk("t5_ovfr_set", 32'(ovf_rtc), 1);
    idle(100);
    chk("t5_sticky", {30'd0, ovf_global, ovf_rtc}, 3);
    do_reset();
    chk("t5_rst_clear", {30'd0, ovf_global, ovf_rtc}, 0);

`ifdef IMPULSE_RX_SNAPSHOT_EN
    // read bank only changes on frame_done
    do_reset();
    for (int c = 0; c < 8; c++) send(4'(c), 16'h1111, 16);
    for (int c = 0; c < 4; c++) send(4'(c), 16'h2222, 16);
    idle(3);
    for (int i = 0; i < 8; i++) rdchk($sformatf("t6_frameA_%0d", i), 4'(i), 16'h1111);
    for (int c = 4; c < 8; c++) send(4'(c), 16'h2222, 16);
    idle(3);
    for (int i = 0; i < 8; i++) rdchk($sformatf("t6_frameB_%0d", i), 4'(i), 16'h2222);
`else
    // read of a channel committed in the same cycle returns the old value
    do_reset();
    send(4'd5, 16'h1111, 16);
    idle(2);
    rd_addr = 4'd5;
    send(4'd5, 16'h2222, 16);
    step(1'b0, 1'b0, 4'd0);
    chk("t6_collide_old", 32'(rd_data), 32'h1111);
    step(1'b0, 1'b0, 4'd0);
    chk("t6_collide_new", 32'(rd_data), 32'h2222);
`endif

    // reset in the middle of a word drops it
    w0 = wv_cnt;
    send(4'd6, 16'hBEEF, 8);
    do_reset();
    idle(20);
    chk("t7_mid_reset_no_wv", wv_cnt - w0, 0);
    chk("t7_mid_reset_err", 32'(err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
